// File: rtl/decode_pkg.sv
// Shared definitions for the instruction window and the decoder that consumes it.
package decode_pkg;

   localparam int WIN_BYTES     = 12;
   localparam int RAW_INSTR_W   = 96;
   localparam int MAX_INSTR_LEN = 12;
   localparam int LEVEL_W       = 6;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      READY = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } win_state_t;

   // Bytes actually retired for a requested length: never more than one
   // maximum-length instruction and never more than is buffered.
   function automatic logic [LEVEL_W-1:0] pop_amount(input logic [3:0]         len,
                                                     input logic [LEVEL_W-1:0] level);
      logic [LEVEL_W-1:0] amt_s;
      amt_s = LEVEL_W'(len);
      if (amt_s > LEVEL_W'(MAX_INSTR_LEN)) begin
         amt_s = LEVEL_W'(MAX_INSTR_LEN);
      end else begin
         amt_s = amt_s;
      end
      if (amt_s > level) begin
         amt_s = level;
      end else begin
         amt_s = amt_s;
      end
      return amt_s;
   endfunction

endpackage

// File: rtl/byte_ring.sv
// Circular byte store: one 4-byte write per cycle, 12-byte rotated read.
// Bytes at or beyond the current fill level read as zero, so the storage
// itself needs no reset to present a clean window.
module byte_ring
   import decode_pkg::*;
#(
   parameter int DEPTH_BYTES = 32,
   localparam int PTR_W = $clog2(DEPTH_BYTES)
) (
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [PTR_W-1:0]       wr_ptr,
   input  logic [31:0]            wr_data,
   input  logic [PTR_W-1:0]       rd_ptr,
   input  logic [LEVEL_W-1:0]     level,
   output logic [RAW_INSTR_W-1:0] rd_window
);

   logic [7:0] mem_r [DEPTH_BYTES];

   // Write the four bytes of an accepted word into consecutive ring slots.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            mem_r[PTR_W'(wr_ptr + PTR_W'(k))] <= wr_data[8*k +: 8];
         end
      end
   end

   // Rotate the ring so the oldest byte lands in bits [7:0]; mask empty slots.
   always_comb begin
      rd_window = '0;
      for (int i = 0; i < WIN_BYTES; i++) begin
         if (LEVEL_W'(i) < level) begin
            rd_window[8*i +: 8] = mem_r[PTR_W'(rd_ptr + PTR_W'(i))];
         end else begin
            rd_window[8*i +: 8] = 8'h00;
         end
      end
   end

endmodule

// File: rtl/instr_window.sv
// Byte-aligning instruction window in front of decode. Buffers 32-bit words,
// presents the oldest 12 bytes and retires the decoded length each cycle.
// Optional statistics counters: define INSTR_WINDOW_STATS_EN.
module instr_window
   import decode_pkg::*;
#(
   parameter int DEPTH_BYTES = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   input  logic [3:0]             consume_len,
   output logic [RAW_INSTR_W-1:0] raw_instr,
   output logic                   out_partial,
   output logic [LEVEL_W-1:0]     level,
   output logic                   err
`ifdef INSTR_WINDOW_STATS_EN
   ,
   output logic [31:0]            stat_instrs,
   output logic [31:0]            stat_stalls
`endif
);

   localparam int PTR_W = $clog2(DEPTH_BYTES);

   win_state_t         state_r;
   win_state_t         state_s;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [LEVEL_W-1:0] level_r;
   logic [LEVEL_W-1:0] level_s;
   logic [LEVEL_W-1:0] pop_amt_s;
   logic [LEVEL_W:0]   free_s;
   logic               push_s;
   logic               pop_s;
   logic               illegal_s;
   logic               in_ready_r;
   logic               in_ready_s;
   logic               out_valid_r;
   logic               out_valid_s;
   logic               out_partial_r;
   logic               out_partial_s;
   logic               err_r;

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign out_partial = out_partial_r;
   assign level       = level_r;
   assign err         = err_r;

   byte_ring #(
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_ring (
      .clk       (clk),
      .wr_en     (push_s && !flush),
      .wr_ptr    (wr_ptr_r),
      .wr_data   (in_data),
      .rd_ptr    (rd_ptr_r),
      .level     (level_r),
      .rd_window (raw_instr)
   );

   // Handshakes, retire amount, next level and next state/flag values.
   always_comb begin
      push_s = in_valid && in_ready_r;
      pop_s  = out_valid_r && out_ready && (consume_len != 4'd0);

      if (pop_s) begin
         pop_amt_s = pop_amount(consume_len, level_r);
         illegal_s = (consume_len > 4'(MAX_INSTR_LEN)) ||
                     (LEVEL_W'(consume_len) > level_r);
      end else begin
         pop_amt_s = '0;
         illegal_s = 1'b0;
      end

      if (push_s) begin
         level_s = level_r + LEVEL_W'(4) - pop_amt_s;
      end else begin
         level_s = level_r - pop_amt_s;
      end

      case (state_r)
         FILL, READY: begin
            if (push_s && in_last) begin
               state_s = DRAIN;
            end else if (level_s >= LEVEL_W'(WIN_BYTES)) begin
               state_s = READY;
            end else begin
               state_s = FILL;
            end
         end
         DRAIN: begin
            if (level_s == '0) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE:    state_s = DONE;
         default: state_s = FILL;
      endcase

      // Credit is taken from the level after this cycle's push and pop.
      free_s     = (LEVEL_W+1)'(DEPTH_BYTES) - {1'b0, level_s};
      in_ready_s = ((state_s == FILL) || (state_s == READY)) &&
                   (free_s >= (LEVEL_W+1)'(4));

      case (state_s)
         READY: begin
            out_valid_s   = 1'b1;
            out_partial_s = 1'b0;
         end
         DRAIN: begin
            out_valid_s   = (level_s != '0);
            out_partial_s = (level_s < LEVEL_W'(WIN_BYTES));
         end
         default: begin
            out_valid_s   = 1'b0;
            out_partial_s = 1'b0;
         end
      endcase
   end

   // Control FSM, pointers, level and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= FILL;
         level_r       <= '0;
         rd_ptr_r      <= '0;
         wr_ptr_r      <= '0;
         in_ready_r    <= 1'b1;
         out_valid_r   <= 1'b0;
         out_partial_r <= 1'b0;
         err_r         <= 1'b0;
      end else if (flush) begin
         state_r       <= FILL;
         level_r       <= '0;
         rd_ptr_r      <= '0;
         wr_ptr_r      <= '0;
         in_ready_r    <= 1'b1;
         out_valid_r   <= 1'b0;
         out_partial_r <= 1'b0;
         err_r         <= err_r;
      end else begin
         state_r       <= state_s;
         level_r       <= level_s;
         rd_ptr_r      <= rd_ptr_r + PTR_W'(pop_amt_s);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(4);
         end
         in_ready_r    <= in_ready_s;
         out_valid_r   <= out_valid_s;
         out_partial_r <= out_partial_s;
         err_r         <= err_r | illegal_s;
      end
   end

`ifdef INSTR_WINDOW_STATS_EN
   logic [31:0] stat_instrs_r;
   logic [31:0] stat_stalls_r;

   assign stat_instrs = stat_instrs_r;
   assign stat_stalls = stat_stalls_r;

   // Saturating counts of retired instructions and consumer stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_instrs_r <= 32'd0;
         stat_stalls_r <= 32'd0;
      end else begin
         if (pop_s && !flush && (stat_instrs_r != 32'hFFFF_FFFF)) begin
            stat_instrs_r <= stat_instrs_r + 32'd1;
         end
         if (out_ready && !out_valid_r && (state_r != DONE) &&
             (stat_stalls_r != 32'hFFFF_FFFF)) begin
            stat_stalls_r <= stat_stalls_r + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_window.sv
// Scoreboard bench for instr_window: a byte-queue reference model predicts the
// state after each edge; a monitor pops predictions and compares the DUT.
module tb_instr_window;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  consume_len;
   logic [95:0] raw_instr;
   logic        out_partial;
   logic [5:0]  level;
   logic        err;
`ifdef INSTR_WINDOW_STATS_EN
   logic [31:0] stat_instrs;
   logic [31:0] stat_stalls;
`endif

   always #5 clk = ~clk;

   instr_window #(.DEPTH_BYTES(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .consume_len (consume_len),
      .raw_instr   (raw_instr),
      .out_partial (out_partial),
      .level       (level),
      .err         (err)
`ifdef INSTR_WINDOW_STATS_EN
      ,
      .stat_instrs (stat_instrs),
      .stat_stalls (stat_stalls)
`endif
   );

   typedef struct packed {
      logic [5:0]  level;
      logic        in_ready;
      logic        out_valid;
      logic        out_partial;
      logic        err;
      logic [95:0] raw;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mq[$];      // reference byte queue, oldest first
   bit         mdrain;     // last word has been accepted
   bit         merr;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Observable behaviour implied by the reference byte queue.
   function automatic exp_t model_view();
      exp_t e;
      int   n;
      n             = mq.size();
      e.level       = 6'(n);
      e.in_ready    = !mdrain && ((32 - n) >= 4);
      e.out_valid   = mdrain ? (n > 0) : (n >= 12);
      e.out_partial = mdrain && (n > 0) && (n < 12);
      e.err         = merr;
      e.raw         = '0;
      for (int i = 0; i < 12; i++) begin
         if (i < n) e.raw[8*i +: 8] = mq[i];
      end
      return e;
   endfunction

   // Drive one cycle of stimulus and enqueue the predicted post-edge state.
   task automatic step(input bit f, input bit v, input logic [31:0] d, input bit last,
                       input bit ordy, input logic [3:0] clen);
      exp_t pre;
      int   n;
      @(negedge clk);
      flush = f; in_valid = v; in_data = d; in_last = last;
      out_ready = ordy; consume_len = clen;
      pre = model_view();
      if (f) begin
         mq.delete();
         mdrain = 1'b0;
      end else begin
         if (pre.out_valid && ordy && (clen != 4'd0)) begin
            n = int'(clen);
            if (n > 12) n = 12;
            if (n > mq.size()) n = mq.size();
            if ((int'(clen) > 12) || (int'(clen) > mq.size())) merr = 1'b1;
            repeat (n) void'(mq.pop_front());
         end
         if (v && pre.in_ready) begin
            for (int k = 0; k < 4; k++) mq.push_back(d[8*k +: 8]);
            if (last) mdrain = 1'b1;
         end
      end
      exp_q.push_back(model_view());
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic push_word(input int w);
      step(1'b0, 1'b1, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic reset_dut();
      idle();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_level", 96'(level), 96'd0);
      chk("rst_in_ready", 96'(in_ready), 96'd1);
      chk("rst_out_valid", 96'(out_valid), 96'd0);
      chk("rst_out_partial", 96'(out_partial), 96'd0);
      chk("rst_err", 96'(err), 96'd0);
      chk("rst_raw", raw_instr, 96'd0);
      #1;
      rst_n = 1'b1;
      mq.delete();
      mdrain = 1'b0;
      merr   = 1'b0;
   endtask

   // Monitor: compare the DUT against each prediction just after its edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("level", 96'(level), 96'(e.level));
            chk("in_ready", 96'(in_ready), 96'(e.in_ready));
            chk("out_valid", 96'(out_valid), 96'(e.out_valid));
            chk("out_partial", 96'(out_partial), 96'(e.out_partial));
            chk("err", 96'(err), 96'(e.err));
            chk("raw_instr", raw_instr, e.raw);
         end
      end
   end

   initial begin
      bit v, f, last, ordy;
      logic [3:0] clen;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0;
      in_last = 1'b0; out_ready = 1'b0; consume_len = 4'd0;
      mdrain = 1'b0; merr = 1'b0;
      reset_dut();

      // Fill to a full window.
      push_word(0); push_word(1); push_word(2);
      settle();
      chk("fill_raw", raw_instr, 96'h0B0A0908_07060504_03020100);
      chk("fill_level", 96'(level), 96'd12);
      chk("fill_valid", 96'(out_valid), 96'd1);

      // Pop 5 with a concurrent push.
      step(1'b0, 1'b1, 32'h0F0E0D0C, 1'b0, 1'b1, 4'd5);
      settle();
      chk("popush_level", 96'(level), 96'd11);
      chk("popush_valid", 96'(out_valid), 96'd0);
      step(1'b0, 1'b1, 32'h13121110, 1'b0, 1'b0, 4'd0);
      settle();
      chk("popush_byte0", 96'(raw_instr[7:0]), 96'h05);

      // Full boundary and pointer wrap.
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0);
      for (int w = 0; w < 8; w++) push_word(w);
      settle();
      chk("full_level", 96'(level), 96'd32);
      chk("full_in_ready", 96'(in_ready), 96'd0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd3);
      settle();
      chk("pop3_in_ready", 96'(in_ready), 96'd0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd1);
      settle();
      chk("pop1_in_ready", 96'(in_ready), 96'd1);
      step(1'b0, 1'b1, 32'hA3A2A1A0, 1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd12);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd12);
      settle();
      chk("wrap_order", 96'(raw_instr[63:0]), 96'h00000000_A3A2A1A0_1F1E1D1C);

      // Drain from a partial window.
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0);
      push_word(0); push_word(1); push_word(2);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd10);
      step(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 4'd0);
      settle();
      chk("drain_partial", 96'(out_partial), 96'd1);
      chk("drain_raw", raw_instr, 96'h0000_0000_0000_DDCC_BBAA_0B0A);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd2);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd4);
      settle();
      chk("done_valid", 96'(out_valid), 96'd0);
      chk("done_in_ready", 96'(in_ready), 96'd0);

      // Illegal length is clamped and sticky across flush.
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0);
      push_word(0); push_word(1); push_word(2);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd13);
      settle();
      chk("illegal_level", 96'(level), 96'd0);
      chk("illegal_err", 96'(err), 96'd1);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0);
      settle();
      chk("flush_keeps_err", 96'(err), 96'd1);
      reset_dut();

      // Flush wins over a simultaneous push and pop.
      push_word(0); push_word(1); push_word(2);
      step(1'b1, 1'b1, 32'h55555555, 1'b0, 1'b1, 4'd4);
      settle();
      chk("flush_level", 96'(level), 96'd0);
      chk("flush_in_ready", 96'(in_ready), 96'd1);
      chk("flush_raw", raw_instr, 96'd0);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         if ((c % 500) == 499) reset_dut();
         f    = ($urandom_range(0, 99) == 0) ||
                (mdrain && (mq.size() == 0) && ($urandom_range(0, 3) == 0));
         v    = ($urandom_range(0, 9) < 7);
         last = ($urandom_range(0, 149) == 0);
         ordy = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 19) == 0) clen = 4'($urandom_range(13, 15));
         else                            clen = 4'($urandom_range(0, 12));
         step(f, v, $urandom, last, ordy, clen);
      end

      idle();
      settle();
      chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
